// File: rtl/mov_izquierda_seq.sv
// Sequential 2048 move-left engine: one row per four-state phase under a start/done handshake.
// Optional win detection is enabled by defining MOV_IZQUIERDA_WIN_DETECT_EN.
module mov_izquierda_seq #(
    parameter int TILE_W    = 12,
    parameter int SCORE_W   = 20,
    parameter int WIN_VALUE = 2048
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [16*TILE_W-1:0]   matrix_in,
    output logic                   busy,
    output logic                   done,
    output logic [16*TILE_W-1:0]   matrix_out,
    output logic [SCORE_W-1:0]     score,
    output logic                   moved,
    output logic                   win
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUEEZE,
        S_MERGE,
        S_RESQUEEZE,
        S_NEXT,
        S_FINISH
    } state_t;

    typedef logic [TILE_W-1:0]  tile_t;
    typedef tile_t [3:0]        row_t;    // [j], column 0 in the low bits
    typedef row_t  [3:0]        board_t;  // [i], row 0 in the low bits

    // Packs the non-zero tiles of a row towards column 0, preserving order.
    function automatic row_t squeeze_row(input row_t t);
        row_t       o;
        logic [2:0] k;
        o = '0;
        k = '0;
        for (int j = 0; j < 4; j++) begin
            if (t[j] != '0) begin
                o[k[1:0]] = t[j];
                k         = k + 3'd1;
            end
        end
        return o;
    endfunction

    // Doubles a tile, clamping to all-ones when the result does not fit.
    function automatic tile_t double_tile(input tile_t v);
        logic [TILE_W:0] s;
        s = {v, 1'b0};
        return s[TILE_W] ? '1 : s[TILE_W-1:0];
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [TILE_W:0]    b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + (SCORE_W + 1)'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    state_t                state_q, state_d;
    logic [1:0]            row_q, row_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    board_t                out_q, out_d;
    logic [SCORE_W-1:0]    score_q, score_d;
    logic                  moved_q, moved_d;

    board_t                work_q, work_d;
    board_t                in_q, in_d;
    logic [SCORE_W-1:0]    acc_q, acc_d;

    row_t                  cur_row;
    row_t                  merged_row;
    logic [TILE_W:0]       merge_gain;

`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
    localparam tile_t WIN_TILE = TILE_W'(WIN_VALUE);
    logic win_hit;
    logic win_flag_q, win_flag_d;
    logic win_q, win_d;
    assign win = win_q;
`else
    localparam bit WIN_CFG_OK = (WIN_VALUE > 0);
    assign win = WIN_CFG_OK & 1'b0;
`endif

    assign cur_row = work_q[row_q];

    // Single left-to-right merge pass over an already squeezed row.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        merged_row = cur_row;
        merge_gain = '0;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
        win_hit = 1'b0;
`endif
        if (cur_row[0] != '0 && cur_row[0] == cur_row[1]) begin
            merged_row[0] = double_tile(cur_row[0]);
            merged_row[1] = '0;
            merge_gain    = merge_gain + {1'b0, merged_row[0]};
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
            win_hit = win_hit | (merged_row[0] == WIN_TILE);
`endif
            if (cur_row[2] != '0 && cur_row[2] == cur_row[3]) begin
                merged_row[2] = double_tile(cur_row[2]);
                merged_row[3] = '0;
                merge_gain    = merge_gain + {1'b0, merged_row[2]};
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
                win_hit = win_hit | (merged_row[2] == WIN_TILE);
`endif
            end
        end else if (cur_row[1] != '0 && cur_row[1] == cur_row[2]) begin
            merged_row[1] = double_tile(cur_row[1]);
            merged_row[2] = '0;
            merge_gain    = merge_gain + {1'b0, merged_row[1]};
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
            win_hit = win_hit | (merged_row[1] == WIN_TILE);
`endif
        end else if (cur_row[2] != '0 && cur_row[2] == cur_row[3]) begin
            merged_row[2] = double_tile(cur_row[2]);
            merged_row[3] = '0;
            merge_gain    = merge_gain + {1'b0, merged_row[2]};
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
            win_hit = win_hit | (merged_row[2] == WIN_TILE);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        score_d = score_q;
        moved_d = moved_q;
        work_d  = work_q;
        in_d    = in_q;
        acc_d   = acc_q;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
        win_flag_d = win_flag_q;
        win_d      = win_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_d    = matrix_in;
                    work_d  = matrix_in;
                    row_d   = 2'd0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SQUEEZE;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
                    win_flag_d = 1'b0;
                    win_d      = 1'b0;
`endif
                end
            end
            S_SQUEEZE: begin
                work_d[row_q] = squeeze_row(cur_row);
                state_d       = S_MERGE;
            end
            S_MERGE: begin
                work_d[row_q] = merged_row;
                acc_d         = sat_add(acc_q, merge_gain);
                state_d       = S_RESQUEEZE;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
                win_flag_d = win_flag_q | win_hit;
`endif
            end
            S_RESQUEEZE: begin
                work_d[row_q] = squeeze_row(cur_row);
                state_d       = S_NEXT;
            end
            S_NEXT: begin
                if (row_q == 2'd3) begin
                    out_d   = work_q;
                    score_d = acc_q;
                    moved_d = (work_q != in_q);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FINISH;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
                    win_d = win_flag_q;
`endif
                end else begin
                    row_d   = row_q + 2'd1;
                    state_d = S_SQUEEZE;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            row_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            score_q <= '0;
            moved_q <= 1'b0;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
            win_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            score_q <= score_d;
            moved_q <= moved_d;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
            win_q   <= win_d;
`endif
        end
    end

    // NOTE: working board, latched input and accumulator are loaded on every accepted
    // start before being read, so they carry no reset.
    always_ff @(posedge clk) begin
        work_q <= work_d;
        in_q   <= in_d;
        acc_q  <= acc_d;
`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
        win_flag_q <= win_flag_d;
`endif
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign matrix_out = out_q;
    assign score      = score_q;
    assign moved      = moved_q;

endmodule

// File: tb/tb_mov_izquierda_seq.sv
// Scoreboard bench for mov_izquierda_seq: directed boards, expected results queued at start,
// compared by a monitor on every done pulse.
module tb_mov_izquierda_seq;

    localparam int TW = 12;
    localparam int SW = 20;

`ifdef MOV_IZQUIERDA_WIN_DETECT_EN
    localparam bit WIN_ON = 1'b1;
`else
    localparam bit WIN_ON = 1'b0;
`endif

    typedef logic [16*TW-1:0] flat_t;
    typedef struct {
        flat_t         m;
        logic [SW-1:0] s;
        logic          mv;
        logic          w;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    flat_t         matrix_in;
    logic          busy, done, moved, win;
    flat_t         matrix_out;
    logic [SW-1:0] score;

    exp_t sb[$];
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   done_cnt = 0;

    mov_izquierda_seq #(.TILE_W(TW), .SCORE_W(SW), .WIN_VALUE(2048)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .matrix_in  (matrix_in),
        .busy       (busy),
        .done       (done),
        .matrix_out (matrix_out),
        .score      (score),
        .moved      (moved),
        .win        (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic flat_t pack(input int v[16]);
        flat_t r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i*TW +: TW] = TW'(v[i]);
        return r;
    endfunction

    // Monitor: every done pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending move");
            end else begin
                e = sb.pop_front();
                check("matrix_out", matrix_out, e.m);
                check("score", score, e.s);
                check("moved", moved, e.mv);
                check("win", win, e.w);
            end
        end
    end

    // Issues one start pulse; the expectation is queued only for moves meant to complete.
    task automatic start_move(input flat_t m, input exp_t e, input bit push);
        @(negedge clk);
        matrix_in = m;
        start     = 1'b1;
        @(posedge clk);
        if (push) sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called right after start_move: the first negedge after the start edge counts as 1.
    task automatic wait_done_latency(input string name);
        int cyc;
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check(name, cyc, 17);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   b[16];
        flat_t basic_in, basic_out;
        exp_t e;
        int   d0;

        rst_n     = 1'b0;
        start     = 1'b0;
        matrix_in = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_matrix", matrix_out, 0);
        check("rst_score", score, 0);
        check("rst_moved", moved, 0);
        check("rst_win", win, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic move
        b = '{0,2,2,0,  0,4,2,2,  2,2,4,0,  4,2,2,4};
        basic_in = pack(b);
        b = '{4,0,0,0,  4,4,0,0,  4,4,0,0,  4,4,4,0};
        basic_out = pack(b);
        e = '{m: basic_out, s: 20'd16, mv: 1'b1, w: 1'b0};
        start_move(basic_in, e, 1'b1);
        check("busy_after_start", busy, 1);
        wait_done_latency("latency_basic");

        // Single-merge rule
        b = '{2,2,2,2,  4,4,8,8,  0,0,0,2,  8,0,0,8};
        matrix_in = pack(b);
        b = '{4,4,0,0,  8,16,0,0,  2,0,0,0,  16,0,0,0};
        e = '{m: pack(b), s: 20'd48, mv: 1'b1, w: 1'b0};
        start_move(matrix_in, e, 1'b1);
        wait_done_latency("latency_single");

        // No-move case
        b = '{2,4,8,16,  4,8,16,32,  2,0,0,0,  0,0,0,0};
        e = '{m: pack(b), s: 20'd0, mv: 1'b0, w: 1'b0};
        start_move(pack(b), e, 1'b1);
        wait_done_latency("latency_nomove");

        // All-zero board
        e = '{m: '0, s: 20'd0, mv: 1'b0, w: 1'b0};
        start_move('0, e, 1'b1);
        wait_done_latency("latency_zero");

        // Handshake: start held for 40 cycles -> accepts at edges 0, 18, 36
        e = '{m: basic_out, s: 20'd16, mv: 1'b1, w: 1'b0};
        d0 = done_cnt;
        @(negedge clk);
        matrix_in = basic_in;
        start     = 1'b1;
        for (int k = 0; k < 3; k++) sb.push_back(e);
        repeat (40) @(negedge clk);
        start = 1'b0;
        check("dones_in_window", done_cnt - d0, 2);
        for (int k = 0; k < 40 && (done_cnt - d0) < 3; k++) @(negedge clk);
        check("dones_total", done_cnt - d0, 3);
        repeat (3) @(negedge clk);

        // Reset mid-move: outputs currently hold the basic result, so zeros are meaningful
        b = '{2,2,0,0,  0,0,0,0,  0,0,0,0,  0,0,0,0};
        start_move(pack(b), e, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_matrix", matrix_out, 0);
        check("abort_score", score, 0);
        check("abort_moved", moved, 0);
        check("abort_win", win, 0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", done_cnt - d0, 0);
        e = '{m: basic_out, s: 20'd16, mv: 1'b1, w: 1'b0};
        start_move(basic_in, e, 1'b1);
        wait_done_latency("latency_after_reset");

        // Win detection
        b = '{1024,1024,0,0,  0,0,0,0,  0,0,0,0,  0,0,0,0};
        matrix_in = pack(b);
        b = '{2048,0,0,0,  0,0,0,0,  0,0,0,0,  0,0,0,0};
        e = '{m: pack(b), s: 20'd2048, mv: 1'b1, w: WIN_ON};
        start_move(matrix_in, e, 1'b1);
        wait_done_latency("latency_win");
        check("win_hold", win, WIN_ON);

        // Tile saturation
        b = '{2048,2048,0,0,  0,0,0,0,  0,0,0,0,  0,0,0,0};
        matrix_in = pack(b);
        b = '{4095,0,0,0,  0,0,0,0,  0,0,0,0,  0,0,0,0};
        e = '{m: pack(b), s: 20'd4095, mv: 1'b1, w: 1'b0};
        start_move(matrix_in, e, 1'b1);
        wait_done_latency("latency_sat");

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mov_izquierda_seq.md
Name: mov_izquierda_seq

Overview:
- Sequential 2048-game move-left engine. Complements the combinational move-right block; direction is mirrored.
- Takes a 4x4 tile matrix and processes one row per phase under a start/done handshake.
- Produces the slid and merged matrix, the move score, and a moved flag.
- Sits between the game-control FSM and the board register. The controller pulses start, waits for done, then commits matrix_out.

Parameters:
- TILE_W, 12, bits per tile value (0 = empty; otherwise a power of two).
- SCORE_W, 20, width of the score accumulator.
- WIN_VALUE, 2048, tile value that raises win (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; accepted only in IDLE.
- matrix_in  input  16*TILE_W  board; element [i][j] at bits [(i*4+j)*TILE_W +: TILE_W]; i = row (0 = top), j = column (0 = leftmost).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- matrix_out  output  16*TILE_W  result, same packing; holds until the next accepted start.
- score  output  SCORE_W  sum of all tiles created by merges in this move.
- moved  output  1  result differs from the latched input.
- win  output  1  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - busy=0, done=0, matrix_out=0, score=0, moved=0, win=0.
  - Assertion mid-operation aborts the move; no done is produced.
- FSM states: IDLE, SQUEEZE, MERGE, RESQUEEZE, NEXT, FINISH.
- IDLE:
  - start=1 latches matrix_in into a working register.
  - Clears row index r=0, the score accumulator and the win flag.
  - Next state is SQUEEZE.
- SQUEEZE (1 cycle): row r non-zero tiles packed to the left, order preserved, zeros fill the right.
- MERGE (1 cycle):
  - Scan j=0..2, left to right.
  - If t[j]!=0 and t[j]==t[j+1]: t[j]=2*t[j], t[j+1]=0, score += new t[j], skip to j+2.
  - Each tile merges at most once per move.
- RESQUEEZE (1 cycle): same as SQUEEZE.
- NEXT:
  - If r==3, go to FINISH.
  - Otherwise r++ and return to SQUEEZE.
- FINISH:
  - Drives matrix_out, score and moved (working result != latched input).
  - done=1 for exactly this cycle; busy drops with done.
  - Next state is IDLE.
- Latency: start sampled at edge 0; done high in the cycle after edge 16 (4 rows x 4 states + FINISH). Fixed, independent of data.
- start while busy is ignored: no restart, no queueing.
- start in the same cycle that done is high is ignored; the FSM must be in IDLE.
- Arithmetic:
  - Doubling is computed in TILE_W+1 bits; if the result exceeds 2^TILE_W-1 the tile saturates to all-ones.
  - Score adds the saturated value.
  - The score accumulator saturates at 2^SCORE_W-1; no wrap.
- Row with no change (e.g. {2,4,8,16}) passes through unchanged and adds 0 to score.
- All-zero board: result all zeros, score=0, moved=0.
- Outputs are registered and hold their values between moves.

Optional Feature:
- Macro: MOV_IZQUIERDA_WIN_DETECT_EN.
- Defined:
  - Any merge producing a value == WIN_VALUE sets a sticky flag for the current move.
  - win is driven with the flag in FINISH and held until the next accepted start, which clears it.
- Undefined: win is tied to 0; no comparator logic is synthesised.

Test Plan:
- Basic move:
  - Stimulus: rows {0,2,2,0},{0,4,2,2},{2,2,4,0},{4,2,2,4}, then start.
  - Response: rows {4,0,0,0},{4,4,0,0},{4,4,0,0},{4,4,4,0}; score=16; moved=1; done exactly 17 cycles after the start edge.
- Single-merge rule:
  - Stimulus: rows {2,2,2,2},{4,4,8,8},{0,0,0,2},{8,0,0,8}.
  - Response: rows {4,4,0,0},{8,16,0,0},{2,0,0,0},{16,0,0,0}; score=4+4+8+16+16=48.
- No-move case:
  - Stimulus: rows {2,4,8,16},{4,8,16,32},{2,0,0,0},{0,0,0,0}.
  - Response: matrix_out equals input; score=0; moved=0.
- Handshake:
  - Stimulus: start held high continuously for 40 cycles.
  - Response: exactly two done pulses, one move per IDLE entry; start during busy ignored.
- Reset mid-move:
  - Stimulus: rst_n=0 at cycle 6 after start.
  - Response: all outputs 0 immediately (async); no done.
  - After release, a fresh start on the basic-move board gives the same result as the basic-move scenario.
- Win and saturation:
  - Stimulus: with MOV_IZQUIERDA_WIN_DETECT_EN, row {1024,1024,0,0}. Then, with or without the macro, row {2048,2048,0,0}.
  - Response: first board gives win=1 and 2048 at column 0. Second board gives column 0 = 4095 (saturated) and score including 4095. Without the macro, win=0 throughout.
